// File: rtl/img_pkg.sv
// Shared pixel/window types for the image streaming blocks.
// Window element k = 3*row + col lives at bits [8k+7:8k] of the flat bus.
package img_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_K    = 3;
  localparam int WIN_BITS = WIN_K * WIN_K * PIX_W;

  typedef logic [PIX_W-1:0] pixel_t;

  // Element 0 (top-left) sits at the least-significant byte.
  typedef pixel_t [WIN_K*WIN_K-1:0] window_t;

  function automatic window_t shift_window(input window_t win,
                                           input pixel_t  top,
                                           input pixel_t  mid,
                                           input pixel_t  bot);
    window_t w;
    w = win;
    for (int i = 0; i < WIN_K; i++) begin
      w[WIN_K*i + 0] = win[WIN_K*i + 1];
      w[WIN_K*i + 1] = win[WIN_K*i + 2];
    end
    w[2] = top;
    w[5] = mid;
    w[8] = bot;
    return w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One raster row of pixel storage; combinational read, synchronous write.
// Reading and writing the same address in one cycle returns the old value.
module line_buffer #(
  parameter  int DEPTH  = 6,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window_3x3.sv
// Streaming 3x3 neighbourhood generator over a padded raster stream.
// One output register; a window is emitted for each interior pixel accepted.
module window_3x3
  import img_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PIX_W-1:0]    data_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [WIN_BITS-1:0] data_out,
  output logic                valid_out,
  input  logic                ready_in
);

  localparam int COL_W  = $clog2(WIDTH) + 1;
  localparam int ROW_W  = $clog2(HEIGHT) + 1;
  localparam int ADDR_W = $clog2(WIDTH);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             emit;
  logic             col_last;
  logic             row_last;
  pixel_t           lb0_rd;
  pixel_t           lb1_rd;
  window_t          win_p0;
  window_t          win_nxt;

  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out;
  assign col_last  = (col == COL_W'(WIDTH - 1));
  assign row_last  = (row == ROW_W'(HEIGHT - 1));
  // Row/col gating hides stale line-buffer contents and row-wrap windows.
  assign emit      = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign win_nxt   = shift_window(win_p0, lb1_rd, lb0_rd, data_in);

  line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (col[ADDR_W-1:0]),
    .wr_data (data_in),
    .rd_data (lb0_rd)
  );

  line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (col[ADDR_W-1:0]),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage p0: window shift register and output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      win_p0    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      if (accept) win_p0 <= win_nxt;
      if (emit) begin
        data_out  <= win_nxt;
        valid_out <= 1'b1;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3.sv
// Self-checking bench for window_3x3: table-driven frames plus hand sequences
// for backpressure, back-to-back frames and mid-frame reset.
module tb_window_3x3;

  localparam int W = 6;
  localparam int H = 6;
  localparam int NWIN = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [71:0] data_out;
  logic        valid_out;
  logic        ready_in = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [71:0] got[$];
  logic [71:0] exp_q[$];

  typedef struct {
    string       name;
    int          kind;
    int          vpct;
    int          rpct;
    logic [71:0] first;
    logic [71:0] last;
  } vec_t;

  vec_t tbl[4];

  window_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  always #5 clk = ~clk;

  // Every completed output handshake is recorded.
  always @(negedge clk) begin
    if (reset && valid_out && ready_in) got.push_back(data_out);
  end

  function automatic logic [71:0] pack9(input int b0, b1, b2, b3, b4, b5, b6, b7, b8);
    logic [71:0] v;
    v = {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    return v;
  endfunction

  // kind 0: counting, 1: 4x4 image 1..16 with zero border, 2: counting + 100
  function automatic int pixel_val(input int kind, input int r, input int c);
    if (kind == 1)
      return (r >= 1 && r <= 4 && c >= 1 && c <= 4) ? (r - 1) * 4 + c : 0;
    else if (kind == 2)
      return W * r + c + 101;
    return W * r + c + 1;
  endfunction

  function automatic logic [71:0] window_at(input int kind, input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[8*(3*i+j) +: 8] = 8'(pixel_val(kind, r - 2 + i, c - 2 + j));
    return v;
  endfunction

  task automatic add_frame(input int kind);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        exp_q.push_back(window_at(kind, r, c));
  endtask

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic compare_seq(input string name);
    check({name, "_count"}, 72'(got.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_win%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic drive_pixel(input int v, input int vpct, input int rpct);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc) begin
      valid_in = ($urandom_range(99) < vpct);
      data_in  = 8'(v);
      ready_in = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc = valid_in && ready_out;
      @(posedge clk);
      #1;
      n++;
      if (n > 2000) begin
        $display("FAIL drive_timeout: got no accept expected accept within 2000 cycles");
        $fatal(1, "stalled");
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int vpct, input int rpct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        drive_pixel(pixel_val(kind, r, c), vpct, rpct);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    ready_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [71:0] held;
    logic [71:0] first_cnt;
    logic [71:0] last_cnt;

    first_cnt = pack9(1, 2, 3, 7, 8, 9, 13, 14, 15);
    last_cnt  = pack9(22, 23, 24, 28, 29, 30, 34, 35, 36);
    tbl[0] = '{"count",      0, 100, 100, first_cnt, last_cnt};
    tbl[1] = '{"padded",     1, 100, 100, pack9(0, 0, 0, 0, 1, 2, 0, 5, 6),
                                          pack9(11, 12, 0, 15, 16, 0, 0, 0, 0)};
    tbl[2] = '{"rand_count", 0,  50,  50, first_cnt, last_cnt};
    tbl[3] = '{"rand_pad",   1,  50,  70, pack9(0, 0, 0, 0, 1, 2, 0, 5, 6),
                                          pack9(11, 12, 0, 15, 16, 0, 0, 0, 0)};

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 72'(valid_out), 72'(0));
    check("reset_data", data_out, '0);
    check("reset_ready", 72'(ready_out), 72'(1));
    reset = 1'b1;
    idle(1);

    for (int t = 0; t < 4; t++) begin
      got.delete();
      exp_q.delete();
      add_frame(tbl[t].kind);
      send_frame(tbl[t].kind, tbl[t].vpct, tbl[t].rpct);
      idle(3);
      compare_seq(tbl[t].name);
      check({tbl[t].name, "_first"}, (got.size() > 0) ? got[0] : 'x, tbl[t].first);
      check({tbl[t].name, "_last"}, (got.size() > 0) ? got[got.size()-1] : 'x, tbl[t].last);
    end

    // Two frames with no gap between them.
    got.delete();
    exp_q.delete();
    add_frame(0);
    add_frame(2);
    send_frame(0, 100, 100);
    send_frame(2, 100, 100);
    idle(3);
    compare_seq("b2b");
    check("b2b_frame2_first", (got.size() > NWIN) ? got[NWIN] : 'x,
          pack9(101, 102, 103, 107, 108, 109, 113, 114, 115));

    // Backpressure on the very first window of a frame.
    got.delete();
    exp_q.delete();
    add_frame(0);
    for (int i = 0; i < 14; i++) drive_pixel(pixel_val(0, i / W, i % W), 100, 100);
    check("pre_first_valid", 72'(valid_out), 72'(0));
    drive_pixel(pixel_val(0, 2, 2), 100, 100);
    check("first_latency", 72'(valid_out), 72'(1));
    check("first_data", data_out, first_cnt);
    held = data_out;
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'(pixel_val(0, 2, 3));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_ready", k), 72'(ready_out), 72'(0));
      check($sformatf("stall%0d_valid", k), 72'(valid_out), 72'(1));
      check($sformatf("stall%0d_data", k), data_out, held);
      @(posedge clk);
      #1;
    end
    for (int i = 15; i < W * H; i++) drive_pixel(pixel_val(0, i / W, i % W), 100, 100);
    idle(3);
    compare_seq("stall");

    // Reset in the middle of a frame.
    for (int i = 0; i < 20; i++) drive_pixel(pixel_val(0, i / W, i % W), 100, 100);
    reset = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_valid", 72'(valid_out), 72'(0));
    check("midreset_data", data_out, '0);
    reset = 1'b1;
    got.delete();
    exp_q.delete();
    add_frame(0);
    send_frame(0, 100, 100);
    idle(3);
    compare_seq("after_reset");
    check("after_reset_first", (got.size() > 0) ? got[0] : 'x, first_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
